// File: rtl/hazard_ctrl_if.sv
// Hazard controller bundle: decode/execute operand and destination info in,
// pipeline register controls and forwarding selects out.
interface hazard_ctrl_if #(
   parameter int RA_W = 5
);
   logic [RA_W-1:0] id_rs1, id_rs2;
   logic            id_use_rs1, id_use_rs2;
   logic [RA_W-1:0] ex_rs1, ex_rs2, ex_rd;
   logic            ex_reg_write, ex_mem_read;
   logic [RA_W-1:0] mem_rd;
   logic            mem_reg_write;
   logic [RA_W-1:0] wb_rd;
   logic            wb_reg_write;
   logic            ex_branch_taken, ex_mdu_op;
   logic            pc_we;
   logic            ifid_we, ifid_flush, idex_we, idex_flush;
   logic            exmem_we, exmem_flush, memwb_we, memwb_flush;
   logic [1:0]      fwd_a, fwd_b;
   logic            mdu_busy, mdu_done;

   modport master (
      output id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rs1, ex_rs2, ex_rd,
             ex_reg_write, ex_mem_read, mem_rd, mem_reg_write, wb_rd,
             wb_reg_write, ex_branch_taken, ex_mdu_op,
      input  pc_we, ifid_we, ifid_flush, idex_we, idex_flush, exmem_we,
             exmem_flush, memwb_we, memwb_flush, fwd_a, fwd_b, mdu_busy, mdu_done
   );

   modport slave (
      input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rs1, ex_rs2, ex_rd,
             ex_reg_write, ex_mem_read, mem_rd, mem_reg_write, wb_rd,
             wb_reg_write, ex_branch_taken, ex_mdu_op,
      output pc_we, ifid_we, ifid_flush, idex_we, idex_flush, exmem_we,
             exmem_flush, memwb_we, memwb_flush, fwd_a, fwd_b, mdu_busy, mdu_done
   );
endinterface

// File: rtl/hazard_ctrl.sv
// 5-stage pipeline hazard controller: load-use stall, branch squash, MDU freeze.
// Macro HAZARD_FWD_EN enables EX forwarding; without it any RAW hazard stalls ID.
module hazard_ctrl #(
   parameter int RA_W       = 5,
   parameter int MDU_CYCLES = 32
) (
   input logic          clk,
   input logic          rst_n,
   hazard_ctrl_if.slave hz
);
   localparam int CNT_W = $clog2(MDU_CYCLES);

   typedef enum logic [1:0] {
      ST_RUN     = 2'd0,
      ST_WAIT    = 2'd1,
      ST_RELEASE = 2'd2
   } state_t;

   state_t           state, state_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic             freeze;
   logic             stall_raw;

   function automatic logic dep(input logic [RA_W-1:0] rs, input logic use_rs,
                                input logic [RA_W-1:0] rd, input logic wr);
      return use_rs && wr && (rd != '0) && (rs == rd);
   endfunction

`ifdef HAZARD_FWD_EN
   function automatic logic [1:0] fwd_sel(input logic [RA_W-1:0] rs);
      if (dep(rs, 1'b1, hz.mem_rd, hz.mem_reg_write))
         return 2'b10;
      else if (dep(rs, 1'b1, hz.wb_rd, hz.wb_reg_write))
         return 2'b01;
      else
         return 2'b00;
   endfunction

   assign stall_raw = hz.ex_mem_read &&
                      (dep(hz.id_rs1, hz.id_use_rs1, hz.ex_rd, 1'b1) ||
                       dep(hz.id_rs2, hz.id_use_rs2, hz.ex_rd, 1'b1));
`else
   assign stall_raw = dep(hz.id_rs1, hz.id_use_rs1, hz.ex_rd, hz.ex_reg_write || hz.ex_mem_read) ||
                      dep(hz.id_rs2, hz.id_use_rs2, hz.ex_rd, hz.ex_reg_write || hz.ex_mem_read) ||
                      dep(hz.id_rs1, hz.id_use_rs1, hz.mem_rd, hz.mem_reg_write) ||
                      dep(hz.id_rs2, hz.id_use_rs2, hz.mem_rd, hz.mem_reg_write);
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_RUN;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   // WAIT lasts MDU_CYCLES-2 cycles: leave once the decrement reaches zero.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      freeze    = 1'b0;
      case (state)
         ST_RUN: begin
            if (hz.ex_mdu_op) begin
               freeze    = 1'b1;
               cnt_nxt   = CNT_W'(MDU_CYCLES - 2);
               state_nxt = (MDU_CYCLES == 2) ? ST_RELEASE : ST_WAIT;
            end
         end
         ST_WAIT: begin
            freeze  = 1'b1;
            cnt_nxt = cnt - 1'b1;
            if (cnt == CNT_W'(1))
               state_nxt = ST_RELEASE;
         end
         ST_RELEASE: state_nxt = ST_RUN;
         default:    state_nxt = ST_RUN;
      endcase
   end

   always_comb begin
      hz.pc_we       = 1'b0;
      hz.ifid_we     = 1'b0;
      hz.ifid_flush  = 1'b0;
      hz.idex_we     = 1'b0;
      hz.idex_flush  = 1'b0;
      hz.exmem_we    = 1'b0;
      hz.exmem_flush = 1'b0;
      hz.memwb_we    = 1'b0;
      hz.memwb_flush = 1'b0;
      hz.fwd_a       = '0;
      hz.fwd_b       = '0;
      hz.mdu_busy    = 1'b0;
      hz.mdu_done    = 1'b0;
      if (rst_n) begin
         hz.pc_we    = 1'b1;
         hz.ifid_we  = 1'b1;
         hz.idex_we  = 1'b1;
         hz.exmem_we = 1'b1;
         hz.memwb_we = 1'b1;
`ifdef HAZARD_FWD_EN
         hz.fwd_a = fwd_sel(hz.ex_rs1);
         hz.fwd_b = fwd_sel(hz.ex_rs2);
`endif
         hz.mdu_busy = (state == ST_WAIT);
         hz.mdu_done = (state == ST_RELEASE);
         if (freeze) begin
            hz.pc_we       = 1'b0;
            hz.ifid_we     = 1'b0;
            hz.idex_we     = 1'b0;
            hz.exmem_flush = 1'b1;
         end else if (hz.ex_branch_taken) begin
            hz.ifid_flush = 1'b1;
            hz.idex_flush = 1'b1;
         end else if (stall_raw) begin
            hz.pc_we      = 1'b0;
            hz.ifid_we    = 1'b0;
            hz.idex_flush = 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed + randomized bench for hazard_ctrl against a cycle-position reference model.
module tb_hazard_ctrl;
   localparam int RA_W = 5;
   localparam int MDU  = 4;

   logic clk;
   logic rst_n;
   int   checks = 0;
   int   errors = 0;
   int   pos    = 0;   // cycles the current MDU op has already spent in EX (0 = none)

   hazard_ctrl_if #(.RA_W(RA_W)) hz ();

   hazard_ctrl #(.RA_W(RA_W), .MDU_CYCLES(MDU)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .hz    (hz.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [1:0] ref_fwd(input logic [RA_W-1:0] rs);
`ifdef HAZARD_FWD_EN
      if (hz.mem_reg_write && hz.mem_rd != 0 && hz.mem_rd == rs) return 2'd2;
      if (hz.wb_reg_write && hz.wb_rd != 0 && hz.wb_rd == rs) return 2'd1;
`endif
      return 2'd0;
   endfunction

   function automatic bit ref_hazard();
      logic [RA_W-1:0] src [2];
      bit              used[2];
      bit              hit = 0;
      src[0] = hz.id_rs1; used[0] = hz.id_use_rs1;
      src[1] = hz.id_rs2; used[1] = hz.id_use_rs2;
      for (int i = 0; i < 2; i++) begin
         if (used[i] && src[i] != 0) begin
            if (hz.ex_mem_read && hz.ex_rd == src[i]) hit = 1;
`ifndef HAZARD_FWD_EN
            if (hz.ex_reg_write && hz.ex_rd == src[i]) hit = 1;
            if (hz.mem_reg_write && hz.mem_rd == src[i]) hit = 1;
`endif
         end
      end
      return hit;
   endfunction

   // {pc, ifid we/fl, idex we/fl, exmem we/fl, memwb we/fl, busy, done, fwd_a, fwd_b}
   function automatic logic [14:0] ref_out();
      bit busy, done, frz;
      logic [8:0] ctl;
      if (!rst_n) return '0;
      busy = (pos >= 1) && (pos <= MDU - 2);
      done = (pos == MDU - 1);
      frz  = busy || (pos == 0 && hz.ex_mdu_op);
      if (frz)                     ctl = 9'b0_00_00_11_10;
      else if (hz.ex_branch_taken) ctl = 9'b1_11_11_10_10;
      else if (ref_hazard())       ctl = 9'b0_00_11_10_10;
      else                         ctl = 9'b1_10_10_10_10;
      return {ctl, busy, done, ref_fwd(hz.ex_rs1), ref_fwd(hz.ex_rs2)};
   endfunction

   task automatic check(input string tag);
      logic [14:0] obs, want;
      obs  = {hz.pc_we, hz.ifid_we, hz.ifid_flush, hz.idex_we, hz.idex_flush,
              hz.exmem_we, hz.exmem_flush, hz.memwb_we, hz.memwb_flush,
              hz.mdu_busy, hz.mdu_done, hz.fwd_a, hz.fwd_b};
      want = ref_out();
      checks++;
      assert (obs === want) else begin
         errors++;
         $error("FAIL %s: observed %b expected %b", tag, obs, want);
      end
   endtask

   task automatic upd();
      if (!rst_n)                    pos = 0;
      else if (pos == 0)             pos = hz.ex_mdu_op ? 1 : 0;
      else if (pos == MDU - 1)       pos = 0;
      else                           pos = pos + 1;
   endtask

   // Inputs are applied 1 after the rising edge, checked at the falling edge.
   task automatic cyc(input string tag);
      #4 check(tag);
      @(posedge clk);
      upd();
      #1;
   endtask

   task automatic idle();
      hz.id_rs1 = '0; hz.id_rs2 = '0; hz.id_use_rs1 = 0; hz.id_use_rs2 = 0;
      hz.ex_rs1 = '0; hz.ex_rs2 = '0; hz.ex_rd = '0;
      hz.ex_reg_write = 0; hz.ex_mem_read = 0;
      hz.mem_rd = '0; hz.mem_reg_write = 0; hz.wb_rd = '0; hz.wb_reg_write = 0;
      hz.ex_branch_taken = 0; hz.ex_mdu_op = 0;
   endtask

   task automatic rand_inputs();
      hz.id_rs1 = RA_W'($urandom_range(0, 3));
      hz.id_rs2 = RA_W'($urandom_range(0, 3));
      hz.id_use_rs1 = 1'($urandom);
      hz.id_use_rs2 = 1'($urandom);
      hz.ex_rs1 = RA_W'($urandom_range(0, 3));
      hz.ex_rs2 = RA_W'($urandom_range(0, 3));
      hz.ex_rd  = RA_W'($urandom_range(0, 3));
      hz.ex_reg_write = 1'($urandom);
      hz.ex_mem_read  = ($urandom_range(0, 2) == 0);
      hz.mem_rd = RA_W'($urandom_range(0, 3));
      hz.mem_reg_write = 1'($urandom);
      hz.wb_rd  = RA_W'($urandom_range(0, 3));
      hz.wb_reg_write = 1'($urandom);
      hz.ex_branch_taken = ($urandom_range(0, 3) == 0);
      hz.ex_mdu_op = (pos != 0) ? 1'b1 : ($urandom_range(0, 5) == 0);
   endtask

   initial begin
      idle();
      rst_n = 1'b0;
      #3 check("reset");
      @(posedge clk); upd(); #1;
      rand_inputs();
      cyc("reset_rand");
      idle();
      rst_n = 1'b1;
      cyc("idle_default");

      hz.ex_mem_read = 1; hz.ex_reg_write = 1; hz.ex_rd = 5;
      hz.id_rs1 = 5; hz.id_use_rs1 = 1;
      cyc("load_use");
      idle();
      cyc("load_use_after");

      hz.ex_mem_read = 1; hz.ex_reg_write = 1; hz.ex_rd = 5;
      hz.id_rs1 = 5; hz.id_use_rs1 = 1; hz.ex_branch_taken = 1;
      cyc("branch_over_lu");
      idle();

      hz.ex_mdu_op = 1;
      for (int i = 0; i < MDU; i++) cyc("mdu_seq");
      hz.ex_mdu_op = 0;
      cyc("mdu_after");

      hz.mem_rd = 7; hz.wb_rd = 7; hz.mem_reg_write = 1; hz.wb_reg_write = 1;
      hz.ex_rs1 = 7; hz.ex_rs2 = 0;
      cyc("fwd_mem");
      hz.mem_reg_write = 0;
      cyc("fwd_wb");
      idle();

      hz.ex_mdu_op = 1;
      cyc("mdu_rst_run");
      cyc("mdu_rst_wait1");
      #2 rst_n = 1'b0;
      #1 check("rst_mid_mdu");
      @(posedge clk); upd(); #1;
      rst_n = 1'b1;
      for (int i = 0; i < MDU; i++) cyc("mdu_restart");
      hz.ex_mdu_op = 0;
      cyc("mdu_restart_after");

      hz.ex_reg_write = 1; hz.ex_rd = 3; hz.id_rs2 = 3; hz.id_use_rs2 = 1;
      cyc("raw_ex");
      idle();
      cyc("raw_ex_after");
      hz.mem_reg_write = 1; hz.mem_rd = 3; hz.id_rs2 = 3; hz.id_use_rs2 = 1;
      cyc("raw_mem");
      idle();
      cyc("raw_mem_after");

      for (int i = 0; i < 400; i++) begin
         rand_inputs();
         if ($urandom_range(0, 59) == 0) rst_n = 1'b0;
         else                            rst_n = 1'b1;
         cyc("random");
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
